// File: rtl/pkt_fifo_pkg.sv
// Shared sizing helpers for the commit/rewind packet FIFO.
package pkt_fifo_pkg;

  function automatic int fifo_depth(input int ptr_w);
    return 1 << ptr_w;
  endfunction

  // EOP tag is stored just above the payload bits in each memory word.
  function automatic int eop_idx(input int data_width);
    return data_width;
  endfunction

  // Modulo distance between two wrap-bit pointers of width ptr_w+1.
  function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << (ptr_w + 1)) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: synchronous write, asynchronous (fall-through) read.
module sdp_ram #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/pkt_fifo_commit.sv
// Packet FIFO that holds words speculatively until EOP, then commits or rewinds.
module pkt_fifo_commit
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int PTR_W        = 6,
  parameter int AF_THRESH    = 48,
  parameter bit DROP_ON_FULL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_sop,
  input  logic                  wr_eop,
  input  logic                  wr_bad,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_eop,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [PTR_W:0]        level,
  output logic [PTR_W:0]        pkt_cnt,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic                  drop
);

  localparam int DEPTH   = fifo_depth(PTR_W);
  localparam int EOP_IDX = eop_idx(DATA_WIDTH);

  typedef logic [PTR_W:0] ptr_t;

  ptr_t rd_q, rd_d, cmt_q, cmt_d, spec_q, spec_d, cnt_q, cnt_d;
  logic poison_q, poison_d, drop_q, drop_d;

  ptr_t spec_occ, eff_occ, base;
  logic pkt_open, resync, eff_full, eff_poison, we, commit, rd_hs;
  logic [DATA_WIDTH:0] rdata;

  assign spec_occ    = ptr_t'(ptr_diff(32'(spec_q), 32'(rd_q), PTR_W));
  assign level       = ptr_t'(ptr_diff(32'(cmt_q), 32'(rd_q), PTR_W));
  assign full        = (spec_occ == ptr_t'(DEPTH));
  assign almost_full = (int'(spec_occ) >= AF_THRESH);
  assign rd_valid    = (rd_q != cmt_q);
  assign empty       = !rd_valid;
  assign pkt_cnt     = cnt_q;
  assign drop        = drop_q;
  assign rd_data     = rdata[DATA_WIDTH-1:0];
  assign rd_eop      = rdata[EOP_IDX];

  always_comb begin
    rd_hs      = rd_valid && rd_ready;
    pkt_open   = (spec_q != cmt_q) || poison_q;
    // SOP on an open packet: abandon it and restart the write at the commit point.
    resync     = wr_en && wr_sop && pkt_open;
    base       = resync ? cmt_q : spec_q;
    eff_occ    = resync ? level : spec_occ;
    eff_full   = (eff_occ == ptr_t'(DEPTH));
    eff_poison = poison_q && !resync;

    rd_d     = rd_q + ptr_t'(rd_hs);
    cmt_d    = cmt_q;
    spec_d   = base;
    poison_d = eff_poison;
    drop_d   = resync;
    we       = 1'b0;
    commit   = 1'b0;

    if (wr_en) begin
      if (eff_poison) begin
        if (wr_eop) begin
          spec_d   = cmt_q;
          poison_d = 1'b0;
          drop_d   = 1'b1;
        end
      end else if (wr_eop && wr_bad) begin
        spec_d = cmt_q;
        drop_d = 1'b1;
      end else if (eff_full) begin
        if (DROP_ON_FULL) begin
          if (wr_eop) begin
            spec_d = cmt_q;
            drop_d = 1'b1;
          end else begin
            poison_d = 1'b1;
          end
        end
      end else begin
        we     = 1'b1;
        spec_d = base + ptr_t'(1);
        if (wr_eop) begin
          cmt_d  = base + ptr_t'(1);
          commit = 1'b1;
        end
      end
    end

    cnt_d = cnt_q + ptr_t'(commit) - ptr_t'(rd_hs && rd_eop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q     <= '0;
      cmt_q    <= '0;
      spec_q   <= '0;
      cnt_q    <= '0;
      poison_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      cmt_q    <= cmt_d;
      spec_q   <= spec_d;
      cnt_q    <= cnt_d;
      poison_q <= poison_d;
      drop_q   <= drop_d;
    end
  end

  sdp_ram #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (we),
    .waddr_i (base[PTR_W-1:0]),
    .wdata_i ({wr_eop, wr_data}),
    .raddr_i (rd_q[PTR_W-1:0]),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_pkt_fifo_commit.sv
// Randomised bench for pkt_fifo_commit against a queue-based packet model.
module tb_pkt_fifo_commit;

  localparam int DW  = 8;
  localparam int PW  = 6;
  localparam int DEP = 64;
  localparam int AF  = 48;

  logic          clk = 1'b0;
  logic          rst, wr_en, wr_sop, wr_eop, wr_bad, rd_ready;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          rd_eop, rd_valid, full, almost_full, empty, drop;
  logic [PW:0]   level, pkt_cnt;

  int pass_cnt = 0;
  int total    = 0;
  bit chk_en   = 1'b0;

  pkt_fifo_commit #(
    .DATA_WIDTH  (DW),
    .PTR_W       (PW),
    .AF_THRESH   (AF),
    .DROP_ON_FULL(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_sop     (wr_sop),
    .wr_eop     (wr_eop),
    .wr_bad     (wr_bad),
    .rd_data    (rd_data),
    .rd_eop     (rd_eop),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .level      (level),
    .pkt_cnt    (pkt_cnt),
    .full       (full),
    .almost_full(almost_full),
    .empty      (empty),
    .drop       (drop)
  );

  always #5 clk = ~clk;

  // Model: committed words (readable) and the open packet's words, each {eop,data}.
  logic [DW:0] cq[$];
  logic [DW:0] sq[$];
  bit          pois;
  bit          drop_e;
  bit          m_hs;
  int          m_occ;

  function automatic int n_eop();
    int n = 0;
    foreach (cq[i]) n += int'(cq[i][DW]);
    return n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      cq.delete();
      sq.delete();
      pois   = 1'b0;
      drop_e = 1'b0;
    end else begin
      m_hs   = (cq.size() != 0) && rd_ready;
      drop_e = 1'b0;
      if (wr_en) begin
        if (wr_sop && (sq.size() != 0 || pois)) begin
          sq.delete();
          pois   = 1'b0;
          drop_e = 1'b1;
        end
        m_occ = cq.size() + sq.size();
        if (pois) begin
          if (wr_eop) begin
            sq.delete();
            pois   = 1'b0;
            drop_e = 1'b1;
          end
        end else if (wr_eop && wr_bad) begin
          sq.delete();
          drop_e = 1'b1;
        end else if (m_occ == DEP) begin
          if (wr_eop) begin
            sq.delete();
            drop_e = 1'b1;
          end else begin
            pois = 1'b1;
          end
        end else begin
          sq.push_back({wr_eop, wr_data});
          if (wr_eop) begin
            foreach (sq[i]) cq.push_back(sq[i]);
            sq.delete();
          end
        end
      end
      if (m_hs) void'(cq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      m_occ = cq.size() + sq.size();
      chk("rd_valid", rd_valid, cq.size() != 0);
      chk("empty", empty, cq.size() == 0);
      if (cq.size() != 0) begin
        chk("rd_data", rd_data, cq[0][DW-1:0]);
        chk("rd_eop", rd_eop, cq[0][DW]);
      end
      chk("level", level, cq.size());
      chk("pkt_cnt", pkt_cnt, n_eop());
      chk("full", full, m_occ == DEP);
      chk("almost_full", almost_full, m_occ >= AF);
      chk("drop", drop, drop_e);
    end
  end

  task automatic cyc(input logic en, input logic [DW-1:0] d, input logic sop,
                     input logic eop, input logic bad, input logic rdy);
    wr_en    = en;
    wr_data  = d;
    wr_sop   = sop;
    wr_eop   = eop;
    wr_bad   = bad;
    rd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (rd_valid && n < 300) begin
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("drain_empty", empty, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("rst_level", level, 0);
    chk("rst_empty", empty, 1);
    chk("rst_drop", drop, 0);

    // Four-word good packet held, then drained.
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 8'hA1 + 8'(i), i == 0, i == 3, 1'b0, 1'b0);
    chk("t1_level", level, 4);
    chk("t1_pkt_cnt", pkt_cnt, 1);
    chk("t1_head", rd_data, 8'hA1);
    drain();
    chk("t1_pkt_cnt_after", pkt_cnt, 0);

    // Bad-CRC packet vanishes, next good packet is intact.
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 8'hB0 + 8'(i), i == 0, i == 2, i == 2, 1'b0);
    chk("t2_drop", drop, 1);
    chk("t2_level", level, 0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_drop_pulse", drop, 0);
    cyc(1'b1, 8'hC1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_head", rd_data, 8'hC1);
    drain();

    // Overflowing 70-word packet is poisoned and dropped at EOP.
    for (int i = 0; i < 70; i++) begin
      cyc(1'b1, 8'(i), i == 0, i == 69, 1'b0, 1'b0);
      if (i == 63) chk("t3_full", full, 1);
    end
    chk("t3_drop", drop, 1);
    chk("t3_level", level, 0);
    chk("t3_full_after", full, 0);

    // Commit a new packet on the same edge the old EOP is read.
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 8'hD0 + 8'(i), i == 0, i == 4, 1'b0, 1'b0);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 8'hE0 + 8'(i), i == 0, i == 2, 1'b0, 1'b1);
    rd_ready = 1'b0;
    chk("t4_pkt_cnt", pkt_cnt, 1);
    chk("t4_level", level, 3);
    chk("t4_head", rd_data, 8'hE0);
    drain();

    // Many 3-word packets with a sluggish reader to wrap pointers and reach almost_full.
    for (int p = 0; p < 40; p++)
      for (int w = 0; w < 3; w++)
        cyc(1'b1, 8'($urandom), w == 0, w == 2, 1'b0, ($urandom % 3) == 0);
    drain();

    // SOP arriving mid-packet drops the stale words and keeps the new packet.
    cyc(1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h21, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_drop", drop, 1);
    cyc(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h23, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_level", level, 3);
    chk("t6_head", rd_data, 8'h21);

    // Reset with a committed packet and an open one discards everything.
    cyc(1'b1, 8'h31, 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_mid_level", level, 0);
    chk("rst_mid_pkt_cnt", pkt_cnt, 0);
    chk("rst_mid_valid", rd_valid, 0);
    chk("rst_mid_drop", drop, 0);

    // Random traffic: gaps, missing EOPs, bad CRCs and random back-pressure.
    for (int i = 0; i < 3000; i++) begin
      logic e;
      e = ($urandom % 6) == 0;
      cyc(($urandom % 4) != 0, 8'($urandom), ($urandom % 9) == 0, e,
          e && (($urandom % 4) == 0), ($urandom % 5) < 2);
    end
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/pkt_fifo_commit.md
Name: pkt_fifo_commit

Overview:
Parametrised successor to the single-packet synchronous FIFO. Stores packet words with a per-word EOP tag and holds written data speculatively until the packet completes. Completion either commits the packet (good CRC) or rewinds it (bad CRC or overflow). Sits between the CRC-checking input stage and the router output arbiter, exposing a valid/ready read side, an exact word level and a committed-packet count.

Parameters:
DATA_WIDTH, 8, payload bits per word
PTR_W, 6, address bits; depth = 2**PTR_W words
AF_THRESH, 48, almost_full asserts when speculative occupancy >= AF_THRESH
DROP_ON_FULL, 1, 1: writes into a full FIFO poison the open packet; 0: writer must respect full (write ignored)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wr_en  in  1  write strobe, one word per cycle
wr_data  in  DATA_WIDTH  write word
wr_sop  in  1  first word of packet (qualified by wr_en)
wr_eop  in  1  last word of packet (qualified by wr_en)
wr_bad  in  1  CRC fail, sampled with wr_eop; discards packet
rd_data  out  DATA_WIDTH  head word (first-word fall-through)
rd_eop  out  1  EOP tag of head word
rd_valid  out  1  committed word available
rd_ready  in  1  consumer accepts head word
level  out  PTR_W+1  committed words held (0..2**PTR_W)
pkt_cnt  out  PTR_W+1  committed packets not yet fully read
full  out  1  speculative occupancy == 2**PTR_W
almost_full  out  1  speculative occupancy >= AF_THRESH
empty  out  1  no committed words (== !rd_valid)
drop  out  1  one-cycle pulse when a packet is discarded

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state updates on the rising edge of clk only.
- Pointers: rd_ptr, cmt_ptr, spec_ptr, each PTR_W+1 bits with a wrap bit. Occupancy is computed by modulo subtraction. Speculative occupancy = spec_ptr - rd_ptr; level = cmt_ptr - rd_ptr.
- Memory is DATA_WIDTH+1 bits wide (data plus EOP). Write happens at spec_ptr when the write is accepted.
- Write acceptance: wr_en && !full && !poisoned. An accepted write increments spec_ptr.
- Good EOP: accepted write with wr_eop && !wr_bad. Sets cmt_ptr <= spec_ptr+1 (includes this word). pkt_cnt increments.
- Bad EOP: wr_en && wr_eop && wr_bad. Sets spec_ptr <= cmt_ptr and pulses drop. The word itself is not retained.
- Overflow, DROP_ON_FULL=1: wr_en while full sets poisoned. Further words are ignored. At the next wr_eop, spec_ptr <= cmt_ptr, drop pulses and poisoned clears.
- Overflow, DROP_ON_FULL=0: wr_en while full is ignored with no state change; the writer is in error.
- wr_sop while a packet is open (spec_ptr != cmt_ptr or poisoned) means the previous EOP was missing. Rewind spec_ptr to cmt_ptr, pulse drop, clear poisoned, then write the SOP word at cmt_ptr in the same cycle.
- Read side: rd_valid = (rd_ptr != cmt_ptr). rd_data/rd_eop are driven combinationally from mem[rd_ptr]. The read handshake is rd_valid && rd_ready, which increments rd_ptr.
- Handshake with rd_eop decrements pkt_cnt. A simultaneous commit and EOP read leaves pkt_cnt unchanged.
- Simultaneous commit and read: level = new cmt_ptr - new rd_ptr. Exact, with no saturation errors; level reaches 2**PTR_W.
- Full/empty use the wrap bit: equal low bits with differing wrap bit means full. Uncommitted words never make rd_valid true.
- Latency: a committed word is visible on rd_valid the cycle after its EOP write.
- Reset values: rd_valid=0, empty=1, full=0, almost_full=0 (AF_THRESH>0), level=0, pkt_cnt=0, drop=0. rd_data/rd_eop are don't-care; memory is not reset.
- Reset mid-packet discards all data, committed and speculative, with no drop pulse.

Decomposition:
- Package pkt_fifo_pkg holds:
  - DEPTH(PTR_W) function
  - EOP bit index constant (= DATA_WIDTH)
  - occupancy subtraction function
- One sub-module, sdp_ram: simple dual-port memory with synchronous write and asynchronous read, parametrised on width and depth.
- Pointer, commit and poison logic live in the top module.

Test Plan:
- Packet 4 words [A1..A4], EOP good, rd_ready=0 → rd_valid rises cycle after A4; level=4, pkt_cnt=1; drain gives A1..A4, rd_eop only on A4, pkt_cnt→0.
- Packet 3 words, wr_bad=1 with EOP → drop pulse 1 cycle; level=0, rd_valid never 1; next good 2-word packet reads back correctly from the same addresses.
- DROP_ON_FULL=1, PTR_W=3: write 10-word packet → full after 8; drop at EOP; level=0, full=0 afterwards.
- Committed 5-word packet, read it while writing a new 3-word packet and committing on the same cycle as the old EOP read → pkt_cnt stays 1, level=3.
- Wrap: 40 packets of 3 words, concurrent read, PTR_W=6 → no data mismatch; full/empty correct across pointer wrap; almost_full toggles at 48.
- Mid-packet wr_sop after 2 words without EOP → drop pulse, new packet stored intact; rst asserted mid-packet → level=0, pkt_cnt=0, rd_valid=0 next cycle.
